wb_line_master: RTL and testbench

- Upstream Wishbone B4 pipelined master that turns one cache-line request (read fill or write-back) into a LINE_WORDS-beat burst on the bus.
- Feeds the RAM slave or interconnect. Collects acks, assembles the read line, and returns a single response to the cache controller.
- Tolerates zero-wait write acks (same cycle as stb), multi-cycle read latency, stall back-pressure, and err/rty.

---
 rtl/ceres_param.sv | 27 ++
 rtl/wb_beat_counter.sv | 49 ++++
 rtl/wb_line_master.sv | 157 +++++++++++++++
 tb/tb_wb_line_master.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ceres_param.sv
// ceres_param: bus types and line geometry shared between the caches and
// their Wishbone B4 (pipelined) masters.
//   LINE_WORDS_DEFAULT : 32-bit words per cache line (default for all users)
//   wb_master_t        : master-to-slave bundle (cyc, stb, we, adr, dat, sel)
//   wb_slave_t         : slave-to-master bundle (dat, ack, err, rty, stall)
package ceres_param;

  localparam int LINE_WORDS_DEFAULT = 4;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_master_t;

  typedef struct packed {
    logic [31:0] dat;
    logic        ack;
    logic        err;
    logic        rty;
    logic        stall;
  } wb_slave_t;

endpackage

// File: rtl/wb_beat_counter.sv
// wb_beat_counter: issue and completion counters for one line burst.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : restart both counters at zero (new line accepted)
//   issue_i       : a beat was accepted by the slave this cycle
//   cpl_i         : ack/err/rty seen this cycle while the bus cycle is open
//   issue_cnt_o   : beats issued so far (0..LINE_WORDS)
//   ack_cnt_o     : completions counted so far (0..LINE_WORDS)
//   cpl_fire_o    : cpl_i is counted (completions beyond the line are dropped)
//   done_o        : this cycle's completion is the last one of the line
// Both counters may step in the same cycle, which covers zero-wait acks.
module wb_beat_counter #(
  parameter int LINE_WORDS = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clr_i,
  input  logic                        issue_i,
  input  logic                        cpl_i,
  output logic [$clog2(LINE_WORDS):0] issue_cnt_o,
  output logic [$clog2(LINE_WORDS):0] ack_cnt_o,
  output logic                        cpl_fire_o,
  output logic                        done_o
);

  localparam int CNT_W = $clog2(LINE_WORDS) + 1;
  localparam logic [CNT_W-1:0] LW_C = CNT_W'(LINE_WORDS);

  logic [CNT_W-1:0] issue_cnt_q;
  logic [CNT_W-1:0] ack_cnt_q;

  assign cpl_fire_o  = cpl_i && (ack_cnt_q < LW_C);
  assign done_o      = cpl_fire_o && (ack_cnt_q == (LW_C - CNT_W'(1)));
  assign issue_cnt_o = issue_cnt_q;
  assign ack_cnt_o   = ack_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      issue_cnt_q <= '0;
      ack_cnt_q   <= '0;
    end else if (clr_i) begin
      issue_cnt_q <= '0;
      ack_cnt_q   <= '0;
    end else begin
      if (issue_i)    issue_cnt_q <= issue_cnt_q + CNT_W'(1);
      if (cpl_fire_o) ack_cnt_q   <= ack_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_line_master.sv
// wb_line_master: turns one cache-line request (fill or write-back) into a
// LINE_WORDS-beat Wishbone B4 pipelined burst and returns one response.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   req_valid_i    : line request valid (accepted only while req_ready_o)
//   req_ready_o    : high in IDLE
//   req_we_i       : 1 = write-back, 0 = fill
//   req_addr_i     : line address, byte-offset bits ignored
//   req_wdata_i    : write line, word k at [32k+31:32k]
//   req_wstrb_i    : byte strobes, word k at [4k+3:4k]
//   rsp_valid_o    : one-cycle completion pulse
//   rsp_rdata_o    : assembled read line, held until the next fill response
//   rsp_err_o      : some beat ended in err or rty (valid with rsp_valid_o)
//   wb_m_o, wb_s_i : Wishbone master / slave bundles
module wb_line_master
  import ceres_param::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_we_i,
  input  logic [31:0]                req_addr_i,
  input  logic [LINE_WORDS*32-1:0]   req_wdata_i,
  input  logic [LINE_WORDS*4-1:0]    req_wstrb_i,
  output logic                       rsp_valid_o,
  output logic [LINE_WORDS*32-1:0]   rsp_rdata_o,
  output logic                       rsp_err_o,
  output wb_master_t                 wb_m_o,
  input  wb_slave_t                  wb_s_i
);

  localparam int OFF_W = $clog2(LINE_WORDS) + 2;
  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LW_C = CNT_W'(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic                     we_q;
  logic [31:0]              base_q;
  logic [LINE_WORDS*32-1:0] wdata_q;
  logic [LINE_WORDS*4-1:0]  wstrb_q;
  logic                     err_q;
  logic [LINE_WORDS*32-1:0] asm_q, asm_d;
  logic [LINE_WORDS*32-1:0] rsp_q;

  logic [CNT_W-1:0] issue_cnt, ack_cnt;
  logic [IDX_W-1:0] issue_idx, ack_idx;
  logic             accept, stb, issue, cpl, cpl_fire, done;

  assign accept    = (state_q == IDLE) && req_valid_i;
  assign stb       = (state_q == BUS) && (issue_cnt < LW_C);
  assign issue     = stb && !wb_s_i.stall;
  // cyc is high exactly in BUS, so acks seen elsewhere are spurious.
  assign cpl       = (state_q == BUS) && (wb_s_i.ack || wb_s_i.err || wb_s_i.rty);
  assign issue_idx = issue_cnt[IDX_W-1:0];
  assign ack_idx   = ack_cnt[IDX_W-1:0];

  wb_beat_counter #(
    .LINE_WORDS (LINE_WORDS)
  ) u_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (accept),
    .issue_i     (issue),
    .cpl_i       (cpl),
    .issue_cnt_o (issue_cnt),
    .ack_cnt_o   (ack_cnt),
    .cpl_fire_o  (cpl_fire),
    .done_o      (done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = BUS;
      BUS:     if (done)        state_d = RESP;
      RESP:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_m_o      = '0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_err_o   = 1'b0;
    unique case (state_q)
      IDLE: req_ready_o = 1'b1;
      BUS: begin
        wb_m_o.cyc = 1'b1;
        wb_m_o.stb = stb;
        wb_m_o.we  = we_q;
        wb_m_o.adr = base_q | {{(30-IDX_W){1'b0}}, issue_idx, 2'b00};
        wb_m_o.dat = wdata_q[issue_idx*32 +: 32];
        wb_m_o.sel = we_q ? wstrb_q[issue_idx*4 +: 4] : 4'hF;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_err_o   = err_q;
      end
      default: ;
    endcase
  end

  // A failed beat (err/rty) leaves its word untouched, so only a clean ack
  // of a fill writes the assembly line.
  always_comb begin
    asm_d = asm_q;
    if (cpl_fire && !we_q && wb_s_i.ack && !wb_s_i.err && !wb_s_i.rty)
      asm_d[ack_idx*32 +: 32] = wb_s_i.dat;
  end

  // Response side: error flag and published line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      if (accept)                                         err_q <= 1'b0;
      else if (cpl_fire && (wb_s_i.err || wb_s_i.rty))    err_q <= 1'b1;
      // The final word is merged in the same edge so the line is complete
      // when rsp_valid_o rises; write-backs never touch the published line.
      if (done && !we_q) rsp_q <= asm_d;
    end
  end

  // Request latch: assembly starts from the last published line so a failed
  // beat keeps that word's previous value.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= req_we_i;
      base_q  <= {req_addr_i[31:OFF_W], {OFF_W{1'b0}}};
      wdata_q <= req_wdata_i;
      wstrb_q <= req_wstrb_i;
      asm_q   <= rsp_q;
    end else begin
      asm_q   <= asm_d;
    end
  end

  assign rsp_rdata_o = rsp_q;

endmodule

// File: tb/tb_wb_line_master.sv
module tb_wb_line_master;
  import ceres_param::*;

  localparam int LW = 4;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [31:0]       req_addr_i;
  logic [LW*32-1:0]  req_wdata_i;
  logic [LW*4-1:0]   req_wstrb_i;
  logic              rsp_valid_o;
  logic [LW*32-1:0]  rsp_rdata_o;
  logic              rsp_err_o;
  wb_master_t        wb_m_o;
  wb_slave_t         wb_s_i;

  wb_line_master #(.LINE_WORDS(LW)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_wstrb_i (req_wstrb_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .wb_m_o      (wb_m_o),
    .wb_s_i      (wb_s_i)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model settings for the current test.
  int  cyc_n, lat, stall_from, stall_to, err_beat, req_hold_until;
  int  beat_n, rsp_cnt;
  bit  idle_ack;
  logic [31:0] rd_word [4];
  int          pend_due [$];
  logic [31:0] pend_dat [$];
  bit          pend_err [$];

  // Per-beat and per-cycle observations.
  logic [31:0] adr_log [16];
  logic [31:0] dat_log [16];
  logic [3:0]  sel_log [16];
  logic        we_log  [16];
  int          beat_cyc [16];
  logic        cyc_at  [32];
  logic        stb_at  [32];
  logic        ready_at [32];
  logic [31:0] adr_at  [32];
  logic [3:0]  sel_at  [32];
  int          rsp_cyc_log [4];
  logic        rsp_err_s;
  logic [127:0] rsp_line_s;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_test();
    cyc_n = 0; beat_n = 0; rsp_cnt = 0;
    lat = 1; stall_from = -1; stall_to = -2; err_beat = -1;
    req_hold_until = 0; idle_ack = 1'b0;
    pend_due.delete(); pend_dat.delete(); pend_err.delete();
    for (int i = 0; i < 4; i++) rsp_cyc_log[i] = -1;
    for (int i = 0; i < 16; i++) beat_cyc[i] = -1;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] addr,
                           input logic [127:0] wdata, input logic [15:0] wstrb);
    req_we_i    = we;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = wstrb;
    req_valid_i = 1'b1;
  endtask

  // One bus cycle, entered and left at the falling edge.
  task automatic step();
    wb_slave_t s;
    logic stl;
    if (cyc_n > req_hold_until) req_valid_i = 1'b0;
    s   = '0;
    stl = (cyc_n >= stall_from) && (cyc_n <= stall_to);
    s.stall = stl;
    if (cyc_n < 32) begin
      cyc_at[cyc_n]   = wb_m_o.cyc;
      stb_at[cyc_n]   = wb_m_o.stb;
      ready_at[cyc_n] = req_ready_o;
      adr_at[cyc_n]   = wb_m_o.adr;
      sel_at[cyc_n]   = wb_m_o.sel;
    end
    if (rsp_valid_o) begin
      if (rsp_cnt < 4) rsp_cyc_log[rsp_cnt] = cyc_n;
      rsp_err_s  = rsp_err_o;
      rsp_line_s = rsp_rdata_o;
      rsp_cnt++;
    end
    if (wb_m_o.cyc && wb_m_o.stb && !stl) begin
      if (beat_n < 16) begin
        adr_log[beat_n]  = wb_m_o.adr;
        dat_log[beat_n]  = wb_m_o.dat;
        sel_log[beat_n]  = wb_m_o.sel;
        we_log[beat_n]   = wb_m_o.we;
        beat_cyc[beat_n] = cyc_n;
      end
      if (wb_m_o.we) begin
        if (beat_n == err_beat) s.err = 1'b1;
        else                    s.ack = 1'b1;
      end else begin
        pend_due.push_back(cyc_n + lat);
        pend_dat.push_back(rd_word[beat_n % 4]);
        pend_err.push_back(beat_n == err_beat);
      end
      beat_n++;
    end
    if (pend_due.size() > 0 && pend_due[0] == cyc_n) begin
      if (pend_err[0]) begin
        s.err = 1'b1;
        s.dat = 32'hDEAD_BEEF;
      end else begin
        s.ack = 1'b1;
        s.dat = pend_dat[0];
      end
      void'(pend_due.pop_front());
      void'(pend_dat.pop_front());
      void'(pend_err.pop_front());
    end
    if (idle_ack) begin
      s.ack = 1'b1;
      s.dat = 32'hBAD0_BAD0;
    end
    wb_s_i = s;
    @(posedge clk_i);
    cyc_n++;
    @(negedge clk_i);
  endtask

  task automatic run_to(input int n);
    while (cyc_n < n) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required $finish");
    $fatal(1);
  end

  initial begin
    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    wb_s_i      = '0;
    start_test();
    #2;
    check("rst_bus",   wb_m_o, '0);
    check("rst_ready", req_ready_o, 1'b1);
    check("rst_rsp_v", rsp_valid_o, 1'b0);
    check("rst_rdata", rsp_rdata_o, '0);
    check("rst_err",   rsp_err_o, 1'b0);
    @(negedge clk_i); @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Read fill, latency 1.
    start_test();
    rd_word = '{32'h11, 32'h22, 32'h33, 32'h44};
    drive_req(1'b0, 32'h0000_1040, '0, '0);
    run_to(10);
    check("t1_ready0", ready_at[0], 1'b1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t1_adr%0d", k), adr_log[k], 32'h1040 + 32'(4*k));
      check($sformatf("t1_cyc%0d", k), beat_cyc[k], k + 1);
      check($sformatf("t1_sel%0d", k), sel_log[k], 4'hF);
      check($sformatf("t1_we%0d", k),  we_log[k], 1'b0);
    end
    check("t1_rsp_cyc", rsp_cyc_log[0], 6);
    check("t1_rsp_cnt", rsp_cnt, 1);
    check("t1_line", rsp_line_s, {32'h44, 32'h33, 32'h22, 32'h11});
    check("t1_err", rsp_err_s, 1'b0);
    check("t1_ready_rsp", ready_at[6], 1'b0);

    // Write-back, zero-wait acks, offset bits ignored.
    start_test();
    drive_req(1'b1, 32'h0000_2007,
              {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0},
              16'hF3FF);
    run_to(8);
    check("t2_adr0", adr_log[0], 32'h2000);
    check("t2_adr3", adr_log[3], 32'h200C);
    check("t2_sel0", sel_log[0], 4'hF);
    check("t2_sel1", sel_log[1], 4'hF);
    check("t2_sel2", sel_log[2], 4'h3);
    check("t2_sel3", sel_log[3], 4'hF);
    check("t2_dat1", dat_log[1], 32'hB1B1_B1B1);
    check("t2_dat2", dat_log[2], 32'hC2C2_C2C2);
    check("t2_we",   we_log[2], 1'b1);
    check("t2_cyc3", beat_cyc[3], 4);
    check("t2_rsp_cyc", rsp_cyc_log[0], 5);
    check("t2_line_kept", rsp_line_s, {32'h44, 32'h33, 32'h22, 32'h11});
    check("t2_err", rsp_err_s, 1'b0);

    // Read with stall on cycles 2-3.
    start_test();
    stall_from = 2; stall_to = 3;
    rd_word = '{32'h55, 32'h66, 32'h77, 32'h88};
    drive_req(1'b0, 32'h0000_1040, '0, '0);
    run_to(11);
    check("t3_adr_st2", adr_at[2], 32'h1044);
    check("t3_adr_st3", adr_at[3], 32'h1044);
    check("t3_sel_st3", sel_at[3], 4'hF);
    check("t3_stb_st3", stb_at[3], 1'b1);
    check("t3_beat1_cyc", beat_cyc[1], 4);
    check("t3_beat3_cyc", beat_cyc[3], 6);
    check("t3_adr1", adr_log[1], 32'h1044);
    check("t3_stb7", stb_at[7], 1'b0);
    check("t3_cyc7", cyc_at[7], 1'b1);
    check("t3_cyc8", cyc_at[8], 1'b0);
    check("t3_rsp_cyc", rsp_cyc_log[0], 8);
    check("t3_line", rsp_line_s, {32'h88, 32'h77, 32'h66, 32'h55});

    // err on beat 2 of a read.
    start_test();
    err_beat = 2;
    rd_word = '{32'h99, 32'hAA, 32'hBB, 32'hCC};
    drive_req(1'b0, 32'h0000_1040, '0, '0);
    run_to(9);
    check("t4_rsp_cyc", rsp_cyc_log[0], 6);
    check("t4_err", rsp_err_s, 1'b1);
    check("t4_line", rsp_line_s, {32'hCC, 32'h77, 32'hAA, 32'h99});
    check("t4_beats", beat_n, 4);

    // Reset in the middle of a read.
    start_test();
    rd_word = '{32'h01, 32'h02, 32'h03, 32'h04};
    drive_req(1'b0, 32'h0000_1040, '0, '0);
    run_to(3);
    check("t5_cyc_pre", wb_m_o.cyc, 1'b1);
    rst_ni = 1'b0;
    #1;
    check("t5_cyc_rst", wb_m_o.cyc, 1'b0);
    check("t5_stb_rst", wb_m_o.stb, 1'b0);
    check("t5_rsp_rst", rsp_valid_o, 1'b0);
    check("t5_rdy_rst", req_ready_o, 1'b1);
    pend_due.delete(); pend_dat.delete(); pend_err.delete();
    run_to(5);
    rst_ni = 1'b1;
    check("t5_no_rsp", rsp_cnt, 0);
    check("t5_rdata_clr", rsp_rdata_o, '0);
    start_test();
    lat = 2;
    drive_req(1'b0, 32'h0000_1040, '0, '0);
    run_to(10);
    check("t5_rdy0", ready_at[0], 1'b1);
    check("t5_rsp_cyc", rsp_cyc_log[0], 7);
    check("t5_line", rsp_line_s, {32'h04, 32'h03, 32'h02, 32'h01});
    check("t5_err", rsp_err_s, 1'b0);

    // Spurious acks while idle, then a request held through RESP.
    start_test();
    idle_ack = 1'b1;
    run_to(3);
    check("t6_idle_rsp", rsp_cnt, 0);
    check("t6_idle_cyc", cyc_at[2], 1'b0);
    start_test();
    rd_word = '{32'hD1, 32'hD2, 32'hD3, 32'hD4};
    req_hold_until = 7;
    drive_req(1'b0, 32'h0000_3000, '0, '0);
    run_to(16);
    check("t6_rsp0_cyc", rsp_cyc_log[0], 6);
    check("t6_rdy_resp", ready_at[6], 1'b0);
    check("t6_cyc7", cyc_at[7], 1'b0);
    check("t6_rdy7", ready_at[7], 1'b1);
    check("t6_beat4_cyc", beat_cyc[4], 8);
    check("t6_adr4", adr_log[4], 32'h3000);
    check("t6_rsp1_cyc", rsp_cyc_log[1], 13);
    check("t6_rsp_cnt", rsp_cnt, 2);
    check("t6_line", rsp_line_s, {32'hD4, 32'hD3, 32'hD2, 32'hD1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
